// File: rtl/init_ram_if.sv
// Bus bundle for init_ram: address/data/strobes in, status flags out.
// OutData is a plain port on the RAM so it can float without an interface net.
interface init_ram_if #(
    parameter int AddressSize = 16,
    parameter int WordSize    = 8
) ();
    logic [AddressSize-1:0] Address;
    logic [WordSize-1:0]    InData;
    logic                   CS;
    logic                   WE;
    logic                   OE;
    logic                   ClearReq;
    logic                   Busy;
    logic                   Error;

    modport master (
        output Address, InData, CS, WE, OE, ClearReq,
        input  Busy, Error
    );

    modport slave (
        input  Address, InData, CS, WE, OE, ClearReq,
        output Busy, Error
    );
endinterface

// File: rtl/init_ram.sv
// Single-port RAM that refills itself with ClearValue after reset or on request.
// Active-low CS/WE/OE strobes, tri-stated read port, sticky contention flag.
module init_ram #(
    parameter int                   AddressSize    = 16,
    parameter int                   WordSize       = 8,
    parameter bit                   RegisteredRead = 1'b0,
    parameter logic [WordSize-1:0]  ClearValue     = '0
) (
    input  logic                clk,
    input  logic                reset,
    init_ram_if.slave           bus,
    output logic [WordSize-1:0] OutData
);
    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                 state;
    logic [AddressSize-1:0] clr_cnt;
    logic                   error;
    logic [WordSize-1:0]    rd_reg;
    logic [WordSize-1:0]    out_val;
    logic                   busy;
    logic                   rd_en;
    logic                   wr_en;

    logic [WordSize-1:0] mem [2**AddressSize];

    assign busy  = (state == CLEAR);
    assign rd_en = !bus.CS && !bus.OE && !busy;
    assign wr_en = !bus.CS && !bus.WE && !busy && !bus.ClearReq;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            error   <= 1'b0;
        end else begin
            if (!bus.WE && !bus.OE)
                error <= 1'b1;
            unique case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (&clr_cnt)
                        state <= IDLE;
                end
                IDLE: begin
                    if (bus.ClearReq) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
            endcase
        end
    end

    // The clear walk owns the array; user writes only land while idle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (busy)
                mem[clr_cnt] <= ClearValue;
            else if (wr_en)
                mem[bus.Address] <= bus.InData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            rd_reg <= ClearValue;
        else if (rd_en)
            rd_reg <= mem[bus.Address];
    end

    assign out_val   = RegisteredRead ? rd_reg : mem[bus.Address];
    assign OutData   = rd_en ? out_val : 'z;
    assign bus.Busy  = busy;
    assign bus.Error = error;
endmodule

// File: tb/tb_init_ram.sv
// Directed bench for init_ram: combinational, registered and 0xFF-fill
// instances driven in lockstep from one set of stimulus variables.
module tb_init_ram;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] addr = '0;
    logic [7:0] din = '0;
    logic       cs = 1'b1;
    logic       we = 1'b1;
    logic       oe = 1'b1;
    logic       clr = 1'b0;
    wire  [7:0] out0, out1, out2;

    int nvec = 0;
    int nerr = 0;
    int n;

    always #5 clk = ~clk;

    init_ram_if #(.AddressSize(4), .WordSize(8)) if0 ();
    init_ram_if #(.AddressSize(4), .WordSize(8)) if1 ();
    init_ram_if #(.AddressSize(4), .WordSize(8)) if2 ();

    assign if0.Address = addr; assign if1.Address = addr; assign if2.Address = addr;
    assign if0.InData  = din;  assign if1.InData  = din;  assign if2.InData  = din;
    assign if0.CS = cs; assign if1.CS = cs; assign if2.CS = cs;
    assign if0.WE = we; assign if1.WE = we; assign if2.WE = we;
    assign if0.OE = oe; assign if1.OE = oe; assign if2.OE = oe;
    assign if0.ClearReq = clr; assign if1.ClearReq = clr; assign if2.ClearReq = clr;

    init_ram #(.AddressSize(4), .WordSize(8), .RegisteredRead(1'b0), .ClearValue(8'h00))
        u0 (.clk(clk), .reset(reset), .bus(if0), .OutData(out0));
    init_ram #(.AddressSize(4), .WordSize(8), .RegisteredRead(1'b1), .ClearValue(8'h00))
        u1 (.clk(clk), .reset(reset), .bus(if1), .OutData(out1));
    init_ram #(.AddressSize(4), .WordSize(8), .RegisteredRead(1'b0), .ClearValue(8'hFF))
        u2 (.clk(clk), .reset(reset), .bus(if2), .OutData(out2));

    typedef struct {
        logic       cs, we, oe;
        logic [3:0] addr;
        logic [7:0] din;
        int         mode;
        logic [7:0] exp;
    } vec_t;

    vec_t vt[12];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Undriven must not show the stored word
    task automatic chk_z(input string nm, input logic [7:0] act, input logic [7:0] drv);
        nvec++;
        if (act === drv) begin
            nerr++;
            $display("FAIL %s: got %h, want high-Z", nm, act);
        end
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (if0.Busy === 1'b1 && cnt < 100) begin
            step();
            cnt++;
        end
    endtask

    task automatic sweep(input string nm);
        for (int a = 0; a < 16; a++) begin
            cs = 1'b0; we = 1'b1; oe = 1'b0; addr = a[3:0];
            #1;
            chk($sformatf("%s u0 a%0d", nm, a), out0, 8'h00);
            chk($sformatf("%s u2 a%0d", nm, a), out2, 8'hFF);
            step();
        end
        cs = 1'b1; oe = 1'b1;
    endtask

    initial begin
        vt[0]  = '{1'b0, 1'b0, 1'b1, 4'h3, 8'hA5, 0, 8'h00};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 4'h3, 8'h00, 1, 8'hA5};
        vt[2]  = '{1'b1, 1'b0, 1'b1, 4'h3, 8'h5A, 0, 8'h00};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 4'h3, 8'h00, 1, 8'hA5};
        vt[4]  = '{1'b1, 1'b1, 1'b0, 4'h3, 8'h00, 2, 8'hA5};
        vt[5]  = '{1'b0, 1'b1, 1'b1, 4'h3, 8'h00, 2, 8'hA5};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 4'h7, 8'h3C, 0, 8'h00};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 4'h7, 8'h00, 1, 8'h3C};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 4'hF, 8'h00, 1, 8'h00};
        vt[9]  = '{1'b0, 1'b0, 1'b1, 4'hF, 8'hC3, 0, 8'h00};
        vt[10] = '{1'b0, 1'b1, 1'b0, 4'hF, 8'h00, 1, 8'hC3};
        vt[11] = '{1'b0, 1'b1, 1'b0, 4'h3, 8'h00, 1, 8'hA5};

        // Power-up reset and first clear
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("reset busy", {7'd0, if0.Busy}, 8'd1);
        chk("reset error", {7'd0, if0.Error}, 8'd0);
        wait_idle(n);
        chk("reset busy cycles", n[7:0], 8'd16);
        sweep("init");

        foreach (vt[i]) begin
            cs = vt[i].cs; we = vt[i].we; oe = vt[i].oe;
            addr = vt[i].addr; din = vt[i].din;
            #1;
            if (vt[i].mode == 1)
                chk($sformatf("vec%0d read", i), out0, vt[i].exp);
            else if (vt[i].mode == 2)
                chk_z($sformatf("vec%0d z", i), out0, vt[i].exp);
            step();
        end
        cs = 1'b1; we = 1'b1; oe = 1'b1;

        // Read and write same address on one edge; also raises contention
        cs = 1'b0; we = 1'b0; oe = 1'b0; addr = 4'h3; din = 8'h11;
        #1;
        chk("rdw old u0", out0, 8'hA5);
        step();
        chk("rdw new u0", out0, 8'h11);
        chk("reg old u1", out1, 8'hA5);
        chk("err set u0", {7'd0, if0.Error}, 8'd1);
        we = 1'b1;
        step();
        chk("reg new u1", out1, 8'h11);
        chk("err held u1", {7'd0, if1.Error}, 8'd1);
        cs = 1'b1; oe = 1'b1;

        // Requested clear: writes and reads blocked while busy
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr busy", {7'd0, if0.Busy}, 8'd1);
        cs = 1'b0; oe = 1'b0; addr = 4'h3;
        #1;
        chk_z("busy z u0", out0, 8'h11);
        oe = 1'b1; we = 1'b0; addr = 4'h9; din = 8'h99;
        wait_idle(n);
        cs = 1'b1; we = 1'b1;
        chk("clr busy cycles", n[7:0], 8'd16);
        chk("err sticky u0", {7'd0, if0.Error}, 8'd1);
        cs = 1'b0; oe = 1'b0; addr = 4'h3;
        #1;
        chk("clr a3 u0", out0, 8'h00);
        chk("clr a3 u2", out2, 8'hFF);
        addr = 4'h9;
        #1;
        chk("busy write ignored", out0, 8'h00);
        cs = 1'b1; oe = 1'b1;

        // Reset at ClrCnt=7, then ClearReq pulses inside the clear
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (7) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst err clear", {7'd0, if0.Error}, 8'd0);
        chk("rst busy", {7'd0, if0.Busy}, 8'd1);
        clr = 1'b1;
        repeat (3) step();
        clr = 1'b0;
        wait_idle(n);
        chk("restart busy cycles", 8'(n + 3), 8'd16);
        sweep("final");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/init_ram.md
INIT_RAM -- requirements
Module: init_ram

Interface
REQ-001 SHALL have parameter AddressSize, default 16, address width in bits; depth is 2^AddressSize words.
REQ-002 SHALL have parameter WordSize, default 8, data width in bits.
REQ-003 SHALL have parameter RegisteredRead, default 0: 0 = combinational read, 1 = one-cycle registered read.
REQ-004 SHALL have parameter ClearValue, default all-zero, WordSize-bit fill value written during clear.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port Address  input  AddressSize  word address.
REQ-008 SHALL have port InData  input  WordSize  write data.
REQ-009 SHALL have port OutData  output  WordSize  read data; high-Z when not driven.
REQ-010 SHALL have ports CS, WE, OE  input  1 each  chip select, write enable and output enable, all active-low.
REQ-011 SHALL have port ClearReq  input  1  active-high request to refill the whole array with ClearValue.
REQ-012 SHALL have port Busy  output  1  high while a clear is in progress.
REQ-013 SHALL have port Error  output  1  sticky bus-contention flag.

Function
REQ-014 SHALL implement a two-state FSM: CLEAR and IDLE; Busy = 1 exactly when the state is CLEAR.
REQ-015 In CLEAR, each posedge SHALL write ClearValue to Mem[ClrCnt] and increment the AddressSize-bit counter ClrCnt.
REQ-016 CLEAR SHALL start with ClrCnt = 0 and last exactly 2^AddressSize cycles; every address, including the top address 2^AddressSize-1, is written.
REQ-017 The edge that writes the top address SHALL move the FSM to IDLE, so Busy is low from the next cycle.
REQ-018 In IDLE, ClearReq = 1 at a posedge SHALL enter CLEAR with ClrCnt = 0; a user write on that same edge is discarded.
REQ-019 ClearReq during CLEAR SHALL be ignored: no restart and no extension.
REQ-020 User write: at posedge with !CS && !WE && !Busy, Mem[Address] <= InData; with CS high or Busy high, no write occurs.
REQ-021 RegisteredRead=0: OutData SHALL equal Mem[Address] combinationally when !CS && !OE && !Busy, else high-Z.
REQ-022 RegisteredRead=0, read-during-write to the same address: old data until the edge, new data after it.
REQ-023 RegisteredRead=1: RdReg SHALL capture Mem[Address] at posedge when !CS && !OE && !Busy (read-first: a same-edge write returns the old value).
REQ-024 RegisteredRead=1: OutData SHALL drive RdReg when !CS && !OE && !Busy, else high-Z.
REQ-025 Error SHALL be set at any posedge with !WE && !OE, regardless of CS or Busy.
REQ-026 Error SHALL stay set until reset; ClearReq does not clear it.
REQ-027 With both WE and OE low, a write SHALL still occur if its conditions hold; OutData behaviour is per REQ-021/024.

Reset
REQ-028 reset = 1 at posedge SHALL force state CLEAR, ClrCnt = 0, Error = 0, RdReg = ClearValue; Busy = 1 from the following cycle.
REQ-029 reset asserted mid-clear SHALL restart the clear from address 0; after reset deasserts, Busy stays high exactly 2^AddressSize cycles.
REQ-030 reset SHALL take priority over ClearReq, user writes and Error set.
REQ-031 Memory contents SHALL be defined only by the clear sequence; there is no reliance on simulation initialisation.

Verification (AddressSize=4, WordSize=8 unless stated)
REQ-032 Reset 1 cycle -> Busy high exactly 16 cycles then low; reads of addresses 0x0..0xF all return 0x00, including 0xF.
REQ-033 Write 0xA5 to 0x3 (CS=0, WE=0), then read (OE=0) -> 0xA5. Write 0x5A to 0x3 with CS=1 -> read still 0xA5. Any read with CS=1 -> high-Z.
REQ-034 RegisteredRead=1, 0x3 holds 0xA5: read-enable plus write 0x11 to 0x3 on one edge -> OutData 0xA5 after that edge, 0x11 after the next read edge.
REQ-035 WE=0 and OE=0 for one cycle -> Error=1 and stays 1 through a ClearReq-triggered clear; the next reset -> Error=0.
REQ-036 ClearReq while 0x3=0xA5 -> Busy 16 cycles. A write during Busy is ignored; OutData is high-Z during Busy; afterwards 0x3 = 0x00.
REQ-037 Reset asserted when ClrCnt=7 -> the clear restarts and Busy lasts 16 cycles after reset deasserts. ClearValue=0xFF build -> all addresses read 0xFF.
